// File: rtl/alu_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// default operand width and the radix-2 Booth pair encodings.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  // {Q0, Q_-1} pairs that require an add/subtract of M before the shift
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, Q_-1}. Purely combinational.
module booth_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] q,
  input  logic           q_m1,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] a_nxt,
  output logic [WIDTH:0] q_nxt,
  output logic           q_m1_nxt
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      BOOTH_SUB: sum = a - m;
      BOOTH_ADD: sum = a + m;
      default:   sum = a;
    endcase
  end

  assign a_nxt    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt    = {sum[0], q[WIDTH:1]};
  assign q_m1_nxt = q[0];
endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle Booth multiplier producing a 2*WIDTH product as hi/lo.
// Optional ALU_MUL_UNSIGNED_EN adds mul_unsigned for zero-extended (MULTU) operation.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef ALU_MUL_UNSIGNED_EN
  input  logic             mul_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t         state;
  logic [WIDTH:0] a, q, m;
  logic           q_m1;
  logic [CW-1:0]  count;
  logic [WIDTH:0] a_nxt, q_nxt;
  logic           q_m1_nxt;
  logic           ext_m, ext_q;

  // Operands are widened by one bit so the most negative value stays exact
`ifdef ALU_MUL_UNSIGNED_EN
  assign ext_m = ~mul_unsigned & multiplicand[WIDTH-1];
  assign ext_q = ~mul_unsigned & multiplier[WIDTH-1];
`else
  assign ext_m = multiplicand[WIDTH-1];
  assign ext_q = multiplier[WIDTH-1];
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .a_nxt    (a_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= {ext_m, multiplicand};
          q     <= {ext_q, multiplier};
          a     <= '0;
          q_m1  <= 1'b0;
          count <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a     <= a_nxt;
          q     <= q_nxt;
          q_m1  <= q_m1_nxt;
          count <= count + 1'b1;
          // Final iteration: latch the low 2*WIDTH bits of {A,Q} straight from the step
          if (count == LAST) begin
            hi    <= {a_nxt[WIDTH-2:0], q_nxt[WIDTH]};
            lo    <= q_nxt[WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
